// File: rtl/ceespu_dmem_ctrl.sv
// ==========================================================================
// ceespu_dmem_ctrl : core data port to 16-bit async SRAM, two half-word phases
// Optional posted-write buffer: CEESPU_DMEM_WBUF_EN      Revision: 1.0
// ==========================================================================
`default_nettype none

module ceespu_dmem_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_dmemE,
   input  logic [3:0]  I_dmemWe,
   input  logic [15:0] I_dmemAddress,
   input  logic [31:0] I_dmemWData,
   output logic [31:0] O_dmemData,
   output logic        O_dmemBusy,
   output logic [14:0] O_sramAddr,
   output logic [15:0] O_sramWData,
   output logic        O_sramDataOe,
   input  logic [15:0] I_sramRData,
   output logic        O_sramCe_n,
   output logic        O_sramOe_n,
   output logic        O_sramWe_n,
   output logic [1:0]  O_sramBe_n
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
   localparam logic       NO_WAIT = (WAIT_CYCLES == 0);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [13:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  we_q, we_d;
   logic        ph_q, ph_d;
   logic        busy_q, busy_d;
   logic [15:0] lo_q, lo_d;
   logic [31:0] rdata_q, rdata_d;
`ifdef CEESPU_DMEM_WBUF_EN
   logic        hold_q, hold_d;
`endif

   logic w_last, w_wr, w_phase, w_accept, w_addr_unused;

   assign w_addr_unused = ^I_dmemAddress[1:0];
   assign w_last  = (cnt_q == 4'd0);
   assign w_wr    = (we_q != 4'b0000);
   assign w_phase = (state_q == ST_LO) || (state_q == ST_HI);

`ifdef CEESPU_DMEM_WBUF_EN
   assign w_accept = I_dmemE && (!busy_q || hold_q);
`else
   assign w_accept = I_dmemE && !busy_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      ph_d    = ph_q;
      busy_d  = busy_q;
      lo_d    = lo_q;
      rdata_d = rdata_q;
`ifdef CEESPU_DMEM_WBUF_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               addr_d  = I_dmemAddress[15:2];
               wdata_d = I_dmemWData;
               we_d    = I_dmemWe;
               cnt_d   = WAIT_LD;
`ifdef CEESPU_DMEM_WBUF_EN
               // Writes are posted: the core only stalls for reads.
               busy_d  = (I_dmemWe == 4'b0000);
               hold_d  = 1'b0;
`else
               busy_d  = 1'b1;
`endif
               if ((I_dmemWe != 4'b0000) && (I_dmemWe[1:0] == 2'b00)) begin
                  state_d = ST_HI;
                  ph_d    = 1'b1;
               end else begin
                  state_d = ST_LO;
                  ph_d    = 1'b0;
               end
            end
`ifdef CEESPU_DMEM_WBUF_EN
            else if (hold_q) begin
               busy_d = 1'b0;
               hold_d = 1'b0;
            end
`endif
         end
         ST_LO: begin
            if (w_last) begin
               if (!w_wr) lo_d = I_sramRData;
               cnt_d = WAIT_LD;
               if (w_wr && (we_q[3:2] == 2'b00)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_HI;
                  ph_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HI: begin
            if (w_last) begin
               // Whole word updates at once so the core never sees a half-new value.
               if (!w_wr) rdata_d = {I_sramRData, lo_q};
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
`ifdef CEESPU_DMEM_WBUF_EN
            busy_d  = hold_q;
`else
            busy_d  = 1'b0;
`endif
         end
      endcase
`ifdef CEESPU_DMEM_WBUF_EN
      if ((state_q != ST_IDLE) && !busy_q && I_dmemE) begin
         busy_d = 1'b1;
         hold_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 14'd0;
         wdata_q <= 32'd0;
         we_q    <= 4'd0;
         ph_q    <= 1'b0;
         busy_q  <= 1'b0;
         lo_q    <= 16'd0;
         rdata_q <= 32'd0;
`ifdef CEESPU_DMEM_WBUF_EN
         hold_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         ph_q    <= ph_d;
         busy_q  <= busy_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
`ifdef CEESPU_DMEM_WBUF_EN
         hold_q  <= hold_d;
`endif
      end
   end

   // Strobes decode straight from reset-cleared registers, so reset kills them at once.
   assign O_dmemData   = rdata_q;
   assign O_dmemBusy   = busy_q;
   assign O_sramAddr   = {addr_q, ph_q};
   assign O_sramWData  = ph_q ? wdata_q[31:16] : wdata_q[15:0];
   assign O_sramCe_n   = !w_phase;
   assign O_sramOe_n   = !(w_phase && !w_wr);
   assign O_sramWe_n   = !(w_phase && w_wr && (!w_last || NO_WAIT));
   assign O_sramDataOe = w_wr && (w_phase || ((state_q == ST_DONE) && NO_WAIT));

   always_comb begin
      O_sramBe_n = 2'b11;
      if (w_phase) begin
         if (!w_wr)     O_sramBe_n = 2'b00;
         else if (ph_q) O_sramBe_n = ~we_q[3:2];
         else           O_sramBe_n = ~we_q[1:0];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ceespu_dmem_ctrl.sv
// Bench for ceespu_dmem_ctrl: transaction-level bus schedule model plus SRAM model.
`default_nettype none

module tb_ceespu_dmem_ctrl;
   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dmem_e = 1'b0;
   logic [3:0]  dmem_we = 4'd0;
   logic [15:0] dmem_addr = 16'd0;
   logic [31:0] dmem_wdata = 32'd0;
   logic [31:0] dmem_data;
   logic        busy;
   logic [14:0] sram_addr;
   logic [15:0] sram_wdata;
   logic        sram_doe;
   logic [15:0] sram_rdata;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic [1:0]  sram_be_n;

   always #5 clk = ~clk;

   ceespu_dmem_ctrl #(.WAIT_CYCLES(W)) dut (
      .I_clk(clk), .I_rst_n(rst_n), .I_dmemE(dmem_e), .I_dmemWe(dmem_we),
      .I_dmemAddress(dmem_addr), .I_dmemWData(dmem_wdata), .O_dmemData(dmem_data),
      .O_dmemBusy(busy), .O_sramAddr(sram_addr), .O_sramWData(sram_wdata),
      .O_sramDataOe(sram_doe), .I_sramRData(sram_rdata), .O_sramCe_n(sram_ce_n),
      .O_sramOe_n(sram_oe_n), .O_sramWe_n(sram_we_n), .O_sramBe_n(sram_be_n)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] init_word(input int i);
      case (i)
         16'h0010: return 16'h1234;
         16'h0011: return 16'hABCD;
         16'h0004: return 16'h1111;
         16'h0005: return 16'h2222;
         16'h7FFE: return 16'hCAFE;
         16'h7FFF: return 16'hF00D;
         default:  return 16'h0000;
      endcase
   endfunction

   // SRAM model: byte-lane writes while selected and write-enabled
   logic [15:0] mem [0:32767];
   logic        mem_init = 1'b0;
   assign sram_rdata = mem[sram_addr];

   // Reference memory and expected per-cycle bus schedule
   logic [15:0] ref_mem [0:32767];
   logic [31:0] exp_data = 32'd0;
   logic        model_on = 1'b1;
   typedef struct packed {
      logic        ce_n, oe_n, we_n;
      logic [1:0]  be_n;
      logic        doe, busy;
      logic [14:0] addr;
      logic [15:0] wdata;
      logic [31:0] data;
   } ent_t;
   ent_t exp_q[$];
   ent_t ce;

   int          wlow = 0;
   logic [14:0] alog[$];

   task automatic model_access(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd);
      ent_t e;
      logic [31:0] nd;
      logic [3:0] lanes;
      logic wr;
      logic [14:0] ha;
      wr = (we != 4'b0000);
      nd = {ref_mem[{a[15:2], 1'b1}], ref_mem[{a[15:2], 1'b0}]};
      for (int p = 0; p < 2; p++) begin
         lanes = we >> (2 * p);
         ha = {a[15:2], 1'(p)};
         if (wr && lanes[1:0] == 2'b00) continue;
         for (int c = 0; c <= W; c++) begin
            e = '0;
            e.ce_n  = 1'b0;
            e.oe_n  = wr;
            e.we_n  = !wr || (c == W && W != 0);
            e.be_n  = wr ? ~lanes[1:0] : 2'b00;
            e.doe   = wr;
            e.busy  = 1'b1;
            e.addr  = ha;
            e.wdata = (p == 1) ? wd[31:16] : wd[15:0];
            e.data  = exp_data;
            exp_q.push_back(e);
         end
         if (wr && lanes[0]) ref_mem[ha][7:0]  = wd[16*p +: 8];
         if (wr && lanes[1]) ref_mem[ha][15:8] = wd[16*p+8 +: 8];
      end
      e = '0;
      e.ce_n = 1'b1; e.oe_n = 1'b1; e.we_n = 1'b1; e.be_n = 2'b11;
      e.doe  = wr && (W == 0);
      e.busy = 1'b1;
      e.data = wr ? exp_data : nd;
      exp_q.push_back(e);
      if (!wr) exp_data = nd;
   endtask

   // Single compare process: every cycle out of reset, DUT against the schedule
   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 32768; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (!sram_ce_n && !sram_we_n) begin
         if (!sram_be_n[0]) mem[sram_addr][7:0]  <= sram_wdata[7:0];
         if (!sram_be_n[1]) mem[sram_addr][15:8] <= sram_wdata[15:8];
      end
      if (!sram_ce_n) begin
         if (!sram_we_n) wlow++;
         if (alog.size() == 0 || alog[alog.size()-1] != sram_addr) alog.push_back(sram_addr);
      end
      if (rst_n && model_on) begin
         if (exp_q.size() > 0) ce = exp_q.pop_front();
         else begin
            ce = '0;
            ce.ce_n = 1'b1; ce.oe_n = 1'b1; ce.we_n = 1'b1; ce.be_n = 2'b11;
            ce.data = exp_data;
         end
         chk("ce_n",  32'(sram_ce_n), 32'(ce.ce_n));
         chk("oe_n",  32'(sram_oe_n), 32'(ce.oe_n));
         chk("we_n",  32'(sram_we_n), 32'(ce.we_n));
         chk("be_n",  32'(sram_be_n), 32'(ce.be_n));
         chk("doe",   32'(sram_doe),  32'(ce.doe));
         chk("busy",  32'(busy),      32'(ce.busy));
         chk("rdata", dmem_data,      ce.data);
         if (!ce.ce_n) chk("addr", 32'(sram_addr), 32'(ce.addr));
         if (!ce.ce_n && ce.doe) chk("wdata", 32'(sram_wdata), 32'(ce.wdata));
      end
   end

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      if (n >= 100) chk("busy_bound", 32'(busy), 32'd0);
   endtask

   task automatic access(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                         output int nbusy);
      wlow = 0;
      alog.delete();
      dmem_e = 1'b1; dmem_addr = a; dmem_we = we; dmem_wdata = wd;
      @(posedge clk); #1;
      model_access(a, we, wd);
      dmem_e = 1'b0; dmem_we = 4'd0; dmem_wdata = 32'd0;
      wait_idle(nbusy);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_data",  dmem_data,       32'd0);
      chk("rst_ce_n",  32'(sram_ce_n),  32'd1);
      chk("rst_oe_n",  32'(sram_oe_n),  32'd1);
      chk("rst_we_n",  32'(sram_we_n),  32'd1);
      chk("rst_be_n",  32'(sram_be_n),  32'd3);
      chk("rst_doe",   32'(sram_doe),   32'd0);
      chk("rst_addr",  32'(sram_addr),  32'd0);
      chk("rst_wdata", 32'(sram_wdata), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      access(16'h0020, 4'b0000, 32'd0, n);
      chk("rd_busy_cycles", n, 7);
      chk("rd_data", dmem_data, 32'hABCD1234);
      chk("rd_addr_count", alog.size(), 2);
      chk("rd_addr_lo", 32'(alog[0]), 32'h0010);

      // Reset during the second cycle of the LO read phase
      dmem_e = 1'b1; dmem_addr = 16'h0020; dmem_we = 4'd0;
      @(posedge clk); #1;
      model_access(16'h0020, 4'd0, 32'd0);
      dmem_e = 1'b0;
      @(posedge clk); #1;
      chk("mid_ce_n", 32'(sram_ce_n), 32'd0);
      rst_n = 1'b0;
      exp_q.delete();
      exp_data = 32'd0;
      #1;
      chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
      chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
      chk("abort_busy", 32'(busy),      32'd0);
      chk("abort_data", dmem_data,      32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      access(16'h0020, 4'b0000, 32'd0, n);
      chk("post_rst_data", dmem_data, 32'hABCD1234);

      access(16'hFFFC, 4'b0000, 32'd0, n);
      chk("wrap_count", alog.size(), 2);
      chk("wrap_a0", 32'(alog[0]), 32'h7FFE);
      chk("wrap_a1", 32'(alog[1]), 32'h7FFF);
      chk("wrap_data", dmem_data, 32'hF00DCAFE);

`ifndef CEESPU_DMEM_WBUF_EN
      access(16'h0040, 4'b1111, 32'hDEADBEEF, n);
      chk("wr_busy_cycles", n, 7);
      chk("wr_we_low", wlow, 4);
      chk("wr_a0", 32'(alog[0]), 32'h0020);
      chk("wr_a1", 32'(alog[1]), 32'h0021);
      chk("wr_keeps_data", dmem_data, 32'hF00DCAFE);
      access(16'h0040, 4'b0000, 32'd0, n);
      chk("wr_readback", dmem_data, 32'hDEADBEEF);

      access(16'h0008, 4'b0100, 32'h00560000, n);
      chk("bw_busy_cycles", n, 4);
      chk("bw_we_low", wlow, 2);
      chk("bw_count", alog.size(), 1);
      chk("bw_addr", 32'(alog[0]), 32'h0005);
      access(16'h0008, 4'b0000, 32'd0, n);
      chk("bw_readback", dmem_data, 32'h22561111);

      access(16'h0008, 4'b0011, 32'h00007788, n);
      chk("hs_busy_cycles", n, 4);
      chk("hs_addr", 32'(alog[0]), 32'h0004);
      access(16'h0008, 4'b0000, 32'd0, n);
      chk("hs_readback", dmem_data, 32'h22567788);

      // A write presented mid-read must be ignored
      dmem_e = 1'b1; dmem_addr = 16'h0020; dmem_we = 4'd0;
      @(posedge clk); #1;
      model_access(16'h0020, 4'd0, 32'd0);
      dmem_e = 1'b0;
      @(posedge clk); #1;
      dmem_e = 1'b1; dmem_addr = 16'h0200; dmem_we = 4'hF; dmem_wdata = 32'h55555555;
      @(posedge clk); #1;
      @(posedge clk); #1;
      dmem_e = 1'b0; dmem_we = 4'd0; dmem_wdata = 32'd0;
      wait_idle(n);
      chk("ign_data", dmem_data, 32'hABCD1234);
      repeat (3) @(posedge clk);
      #1;
      chk("ign_mem", 32'(mem[15'h0100]), 32'h0000);
`else
      model_on = 1'b0;
      dmem_e = 1'b1; dmem_addr = 16'h0100; dmem_we = 4'hF; dmem_wdata = 32'h11223344;
      @(posedge clk); #1;
      chk("wb_post_busy", 32'(busy), 32'd0);
      dmem_we = 4'd0; dmem_wdata = 32'd0;
      @(posedge clk); #1;
      chk("wb_hold_busy", 32'(busy), 32'd1);
      wait_idle(n);
      dmem_e = 1'b0;
      chk("wb_rdata", dmem_data, 32'h11223344);
      chk("wb_mem_lo", 32'(mem[15'h0080]), 32'h3344);
      chk("wb_mem_hi", 32'(mem[15'h0081]), 32'h1122);
`endif
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/ceespu_dmem_ctrl.md
Name: ceespu_dmem_ctrl

Overview:
Data-memory controller between the ceespu core's data port and an external 16-bit asynchronous SRAM. It accepts 32-bit word reads and byte-enabled writes from the core and splits each one into two half-word SRAM phases with programmable wait states. While an access is in flight it stalls the core through a busy handshake. It is the block that drives the core's I_dmemData and I_dmemBusy inputs.

Parameters:
WAIT_CYCLES, 2, extra SRAM cycles per half-word phase; each phase lasts WAIT_CYCLES+1 clocks (legal range 0..15).

Ports:
I_clk  in  1  system clock, rising edge.
I_rst_n  in  1  asynchronous reset, active-low.
I_dmemE  in  1  core access request.
I_dmemWe  in  4  byte write enables; 4'b0000 means read. Bit 0 is byte [7:0].
I_dmemAddress  in  16  byte address; bits [1:0] ignored (word access).
I_dmemWData  in  32  write data.
O_dmemData  out  32  read data, fed to core I_dmemData.
O_dmemBusy  out  1  stall to core, fed to core I_dmemBusy.
O_sramAddr  out  15  half-word address = {I_dmemAddress[15:2], phase}.
O_sramWData  out  16  SRAM write data.
O_sramDataOe  out  1  1 = controller drives the SRAM data bus.
I_sramRData  in  16  SRAM read data.
O_sramCe_n  out  1  chip enable, active-low.
O_sramOe_n  out  1  output enable, active-low.
O_sramWe_n  out  1  write enable, active-low.
O_sramBe_n  out  2  byte lane enables, active-low.

Behaviour:
- Reset (async assert, sync deassert at the core level): state IDLE; O_dmemBusy=0; O_dmemData=0; O_sramCe_n=O_sramOe_n=O_sramWe_n=1; O_sramBe_n=2'b11; O_sramDataOe=0; O_sramAddr=0; O_sramWData=0. Reset asserted mid-access abandons the access immediately and deasserts all strobes in the same instant.
- Accept rule: a request is captured at the posedge where I_dmemE=1 and O_dmemBusy=0 and the state is IDLE. Address, WData and We are latched at that edge. O_dmemBusy (registered) goes high on that same edge. Requests while busy are ignored.
- FSM:
  - IDLE -> LO on accept.
  - LO -> HI after WAIT_CYCLES+1 clocks.
  - HI -> DONE after WAIT_CYCLES+1 clocks.
  - DONE -> IDLE after 1 clock; O_dmemBusy drops on entering IDLE.
  - Phase skip on write: if We[1:0]==0, LO is skipped (go straight to HI). If We[3:2]==0, HI is skipped (LO -> DONE). Reads always run both phases.
- Phase LO uses sramAddr LSB 0 and data bits [15:0]. Phase HI uses LSB 1 and bits [31:16].
- During a phase, O_sramCe_n=0 and address, data and Be_n are held constant for the whole phase. Counter loads WAIT_CYCLES and decrements to 0.
- Read phase: Oe_n=0, We_n=1, DataOe=0, Be_n=00. I_sramRData is sampled on the last clock of the phase into the matching half of O_dmemData.
- Write phase: Oe_n=1, DataOe=1, Be_n=~We[1:0] (LO) or ~We[3:2] (HI). We_n=0 on every cycle of the phase except the last, where We_n=1 so data holds through the write-end. When WAIT_CYCLES=0, We_n is low for the single phase cycle and data stays driven through DONE.
- Busy cycles: full read = 2*(WAIT_CYCLES+1)+1 (7 at default). A write is shorter when a phase is skipped.
- O_dmemData holds its value until the next read completes. Writes never modify it.
- Address wrap: word 0x3FFF maps to half-word addresses 0x7FFE and 0x7FFF. There is no overflow.

Optional Feature:
CEESPU_DMEM_WBUF_EN:
- Defined: one-entry posted-write buffer. A write accepted from IDLE does not raise O_dmemBusy; it is latched and drained through the FSM in the background.
- A new request arriving while the buffer is draining raises O_dmemBusy the next cycle and is held off until the drain reaches IDLE. The held request is then accepted.
- A read to the same word as a draining write therefore returns the new data.
- Not defined: writes stall exactly like reads, as described above.

Test Plan:
- Reset then read: SRAM returns 0x1234 at half-word 0x0010 and 0xABCD at 0x0011; read byte address 0x0020 with WAIT_CYCLES=2 -> busy high 7 cycles, then O_dmemData=0xABCD1234.
- Full write 0xDEADBEEF to 0x0040, We=1111 -> LO phase: addr 0x0020, data 0xBEEF, Be_n=00, We_n low for 2 cycles. HI phase: addr 0x0021, data 0xDEAD. Busy 7 cycles.
- Byte write We=0100, data 0x00560000 to 0x0008 -> LO skipped. Single HI phase at addr 0x0005, data 0x0056, Be_n=10. Busy 4 cycles.
- Reset asserted on cycle 2 of a read phase -> Ce_n, Oe_n go 1 immediately; busy=0; next request after reset completes normally.
- Wrap: read 0xFFFC -> sramAddr sequence 0x7FFE, 0x7FFF.
- CEESPU_DMEM_WBUF_EN: write 0x11223344 to 0x0100 followed next cycle by a read of 0x0100 -> write accepted with no busy; read stalls until drain finishes and returns 0x11223344.
